// File: rtl/conv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : conv_pkg
// Description : Shared constants, pixel type and window indexing helper for
//               the convolution window generator and multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
package conv_pkg;

    localparam int c_BITS        = 9;
    localparam int c_KERNEL_SIZE = 3;

    typedef logic signed [c_BITS-1:0] pixel_t;

    // Bit offset of window element (r,c); r=0 is the top row, c=0 the left column.
    function automatic int win_offset(input int r, input int c,
                                      input int ksize, input int bits);
        return (r * ksize + c) * bits;
    endfunction

endpackage : conv_pkg
`default_nettype wire

// File: rtl/conv_window_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : conv_window_gen_if
// Description : Pixel stream in / packed window out bundle for
//               conv_window_gen. Carries sof only with CONV_FRAME_SYNC_EN.
// Revision    : 1.0 - initial release
// ============================================================================
interface conv_window_gen_if
    import conv_pkg::*;
#(
    parameter int BITS        = c_BITS,
    parameter int KERNEL_SIZE = c_KERNEL_SIZE
);

    logic [BITS-1:0]                          pixel_in;
    logic                                     pixel_valid;
`ifdef CONV_FRAME_SYNC_EN
    logic                                     sof;
`endif
    logic [KERNEL_SIZE*KERNEL_SIZE*BITS-1:0]  shift_in;
    logic                                     out_en;
    logic                                     frame_done;

`ifdef CONV_FRAME_SYNC_EN
    modport master (
        output pixel_in, pixel_valid, sof,
        input  shift_in, out_en, frame_done
    );

    modport slave (
        input  pixel_in, pixel_valid, sof,
        output shift_in, out_en, frame_done
    );
`else
    modport master (
        output pixel_in, pixel_valid,
        input  shift_in, out_en, frame_done
    );

    modport slave (
        input  pixel_in, pixel_valid,
        output shift_in, out_en, frame_done
    );
`endif

endinterface : conv_window_gen_if
`default_nettype wire

// File: rtl/conv_line_buffer.sv
`default_nettype none
// ============================================================================
// Module      : conv_line_buffer
// Description : One image row of storage, column indexed, with the read port
//               showing the old contents of the addressed column.
// Revision    : 1.0 - initial release
// ============================================================================
module conv_line_buffer #(
    parameter int BITS   = 9,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  wire logic              clk,
    input  wire logic              i_we,
    input  wire logic [ADDR_W-1:0] i_addr,
    input  wire logic [BITS-1:0]   i_wdata,
    output logic      [BITS-1:0]   o_rdata
);

    // Contents are deliberately not reset; the row qualifier masks stale data.
    logic [BITS-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule : conv_line_buffer
`default_nettype wire

// File: rtl/conv_window_gen.sv
`default_nettype none
// ============================================================================
// Module      : conv_window_gen
// Description : Streaming KxK window generator (K=3) over a raster pixel
//               stream; emits each fully populated window one cycle after its
//               bottom-right pixel. Optional CONV_FRAME_SYNC_EN adds sof.
// Revision    : 1.0 - initial release
// ============================================================================
module conv_window_gen
    import conv_pkg::*;
#(
    parameter int BITS        = c_BITS,
    parameter int KERNEL_SIZE = c_KERNEL_SIZE,
    parameter int IMG_WIDTH   = 32,
    parameter int IMG_HEIGHT  = 32
) (
    input wire logic         clk,
    input wire logic         rst,
    conv_window_gen_if.slave bus
);

    localparam int c_COL_W = $clog2(IMG_WIDTH);
    localparam int c_ROW_W = $clog2(IMG_HEIGHT);
    localparam int c_WIN_W = KERNEL_SIZE * KERNEL_SIZE * BITS;
    localparam int c_NLB   = KERNEL_SIZE - 1;

    if (KERNEL_SIZE != 3) begin : g_bad_kernel
        $error("conv_window_gen: only KERNEL_SIZE = 3 is supported");
    end
    if (IMG_WIDTH < KERNEL_SIZE || IMG_HEIGHT < KERNEL_SIZE) begin : g_bad_image
        $error("conv_window_gen: image must be at least KERNEL_SIZE on each side");
    end

    logic [c_COL_W-1:0] r_col;
    logic [c_ROW_W-1:0] r_row;
    logic [c_WIN_W-1:0] r_win;
    logic               r_out_en;
    logic               r_frame_done;

    logic               w_accept;
    logic               w_sof;
    logic [c_COL_W-1:0] w_col;
    logic [c_ROW_W-1:0] w_row;
    logic               w_last_col;
    logic               w_last_row;
    logic [BITS-1:0]    w_lb_rd  [c_NLB];
    logic [BITS-1:0]    w_new_col[KERNEL_SIZE];

    assign w_accept = bus.pixel_valid & ~rst;

`ifdef CONV_FRAME_SYNC_EN
    assign w_sof = bus.pixel_valid & bus.sof;
`else
    assign w_sof = 1'b0;
`endif

    // sof forces the accepted pixel to (0,0) regardless of the running counters.
    assign w_col      = w_sof ? '0 : r_col;
    assign w_row      = w_sof ? '0 : r_row;
    assign w_last_col = (w_col == c_COL_W'(IMG_WIDTH - 1));
    assign w_last_row = (w_row == c_ROW_W'(IMG_HEIGHT - 1));

    // Buffer 0 holds row r-1 and takes the new pixel; each older buffer takes
    // the column its younger neighbour is about to overwrite.
    for (genvar i = 0; i < c_NLB; i++) begin : g_lb
        logic [BITS-1:0] w_wdata;

        if (i == 0) begin : g_first
            assign w_wdata = bus.pixel_in;
        end else begin : g_chain
            assign w_wdata = w_lb_rd[i-1];
        end

        conv_line_buffer #(
            .BITS   (BITS),
            .DEPTH  (IMG_WIDTH),
            .ADDR_W (c_COL_W)
        ) u_lb (
            .clk     (clk),
            .i_we    (w_accept),
            .i_addr  (w_col),
            .i_wdata (w_wdata),
            .o_rdata (w_lb_rd[i])
        );
    end

    // Rightmost window column, top (oldest row) to bottom (current pixel).
    always_comb begin
        for (int r = 0; r < KERNEL_SIZE; r++) begin
            w_new_col[r] = '0;
        end
        for (int r = 0; r < KERNEL_SIZE - 1; r++) begin
            w_new_col[r] = w_lb_rd[KERNEL_SIZE-2-r];
        end
        w_new_col[KERNEL_SIZE-1] = bus.pixel_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_col        <= '0;
            r_row        <= '0;
            r_win        <= '0;
            r_out_en     <= 1'b0;
            r_frame_done <= 1'b0;
        end else if (w_accept) begin
            for (int r = 0; r < KERNEL_SIZE; r++) begin
                for (int c = 0; c < KERNEL_SIZE - 1; c++) begin
                    r_win[win_offset(r, c, KERNEL_SIZE, BITS) +: BITS] <=
                        r_win[win_offset(r, c + 1, KERNEL_SIZE, BITS) +: BITS];
                end
                r_win[win_offset(r, KERNEL_SIZE - 1, KERNEL_SIZE, BITS) +: BITS] <=
                    w_new_col[r];
            end

            if (w_last_col) begin
                r_col <= '0;
                r_row <= w_last_row ? '0 : w_row + 1'b1;
            end else begin
                r_col <= w_col + 1'b1;
                r_row <= w_row;
            end

            // Columns below K-1 would mix the end of the previous row into the window.
            r_out_en     <= (w_row >= c_ROW_W'(KERNEL_SIZE - 1)) &&
                            (w_col >= c_COL_W'(KERNEL_SIZE - 1));
            r_frame_done <= w_last_row && w_last_col;
        end else begin
            r_out_en     <= 1'b0;
            r_frame_done <= 1'b0;
        end
    end

    assign bus.shift_in   = r_win;
    assign bus.out_en     = r_out_en;
    assign bus.frame_done = r_frame_done;

endmodule : conv_window_gen
`default_nettype wire

// File: tb/tb_conv_window_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv_window_gen
// Description : Directed self-checking bench for conv_window_gen on a 4x4
//               image with pixel value = base + row*4 + col.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_conv_window_gen;
    import conv_pkg::*;

    localparam int c_BITS_TB = 9;
    localparam int c_K       = 3;
    localparam int c_W       = 4;
    localparam int c_H       = 4;
    localparam int c_WIN_W   = c_K * c_K * c_BITS_TB;

    logic clk;
    logic rst;

    int n_checks;
    int n_pass;
    int n_win;
    int n_done;

    conv_window_gen_if #(.BITS(c_BITS_TB), .KERNEL_SIZE(c_K)) bus ();

    conv_window_gen #(
        .BITS        (c_BITS_TB),
        .KERNEL_SIZE (c_K),
        .IMG_WIDTH   (c_W),
        .IMG_HEIGHT  (c_H)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] obs,
                            input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Window whose bottom-right pixel has raster index p (row >= 2, col >= 2).
    function automatic logic [c_WIN_W-1:0] exp_win(input int base, input int p);
        logic [c_WIN_W-1:0] w;
        w = '0;
        for (int r = 0; r < c_K; r++) begin
            for (int c = 0; c < c_K; c++) begin
                w[(r*c_K + c)*c_BITS_TB +: c_BITS_TB] =
                    c_BITS_TB'(base + p - (2 - r)*c_W - (2 - c));
            end
        end
        return w;
    endfunction

    task automatic step(input bit v, input int pix, input bit s, input bit exp_en,
                        input int base, input int p, input bit exp_done);
        bus.pixel_valid = v;
        bus.pixel_in    = c_BITS_TB'(pix);
`ifdef CONV_FRAME_SYNC_EN
        bus.sof         = s;
`else
        if (s) $display("note: sof requested without frame sync build");
`endif
        @(posedge clk);
        #1;
        check_eq("out_en", 128'(bus.out_en), 128'(exp_en));
        if (exp_en) begin
            check_eq("window", 128'(bus.shift_in), 128'(exp_win(base, p)));
        end
        check_eq("frame_done", 128'(bus.frame_done), 128'(exp_done));
        if (bus.out_en)     n_win++;
        if (bus.frame_done) n_done++;
        bus.pixel_valid = 1'b0;
`ifdef CONV_FRAME_SYNC_EN
        bus.sof         = 1'b0;
`endif
    endtask

    task automatic run_frame(input int base, input bit gaps, input bit sof_first);
        for (int p = 0; p < c_W*c_H; p++) begin
            if (gaps) step(1'b0, 0, 1'b0, 1'b0, base, p, 1'b0);
            step(1'b1, base + p, sof_first && (p == 0),
                 (p / c_W >= 2) && (p % c_W >= 2), base, p, p == c_W*c_H - 1);
        end
    endtask

    initial begin
        pixel_t px;
        int     sum;
        n_checks = 0;
        n_pass   = 0;
        n_win    = 0;
        n_done   = 0;
        rst             = 1'b1;
        bus.pixel_valid = 1'b0;
        bus.pixel_in    = '0;
`ifdef CONV_FRAME_SYNC_EN
        bus.sof         = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_shift_in",   128'(bus.shift_in),   128'(0));
        check_eq("rst_out_en",     128'(bus.out_en),     128'(0));
        check_eq("rst_frame_done", 128'(bus.frame_done), 128'(0));
        rst = 1'b0;

        // Back-to-back frame
        run_frame(0, 1'b0, 1'b0);
        check_eq("b2b_win_count",  128'(n_win),  128'(4));
        check_eq("b2b_done_count", 128'(n_done), 128'(1));

        // Second frame straight after: windows must hold only new-frame pixels
        n_win = 0;
        run_frame(100, 1'b0, 1'b0);
        check_eq("f2_win_count",  128'(n_win),  128'(4));
        check_eq("f2_done_count", 128'(n_done), 128'(2));

        // Idle cycle before every pixel
        n_win = 0; n_done = 0;
        run_frame(50, 1'b1, 1'b0);
        check_eq("gap_win_count",  128'(n_win),  128'(4));
        check_eq("gap_done_count", 128'(n_done), 128'(1));

        // Reset after pixel 9, asserted together with a valid pixel
        n_win = 0; n_done = 0;
        for (int p = 0; p < 10; p++) step(1'b1, p, 1'b0, 1'b0, 0, p, 1'b0);
        rst             = 1'b1;
        bus.pixel_valid = 1'b1;
        bus.pixel_in    = c_BITS_TB'(99);
        @(posedge clk);
        #1;
        check_eq("midrst_out_en",   128'(bus.out_en),     128'(0));
        check_eq("midrst_shift_in", 128'(bus.shift_in),   128'(0));
        check_eq("midrst_done",     128'(bus.frame_done), 128'(0));
        rst             = 1'b0;
        bus.pixel_valid = 1'b0;
        run_frame(20, 1'b0, 1'b0);
        check_eq("midrst_win_count",  128'(n_win),  128'(4));
        check_eq("midrst_done_count", 128'(n_done), 128'(1));

        // All-ones image: a 3x3 all-ones kernel must sum to 9 on each window
        n_win = 0;
        for (int p = 0; p < c_W*c_H; p++) begin
            bus.pixel_valid = 1'b1;
            bus.pixel_in    = c_BITS_TB'(1);
            @(posedge clk);
            #1;
            check_eq("ones_out_en", 128'(bus.out_en),
                     128'((p / c_W >= 2) && (p % c_W >= 2)));
            if (bus.out_en) begin
                n_win++;
                sum = 0;
                for (int e = 0; e < c_K*c_K; e++) begin
                    px  = bus.shift_in[e*c_BITS_TB +: c_BITS_TB];
                    sum = sum + int'(px);
                end
                check_eq("ones_sum", 128'(sum), 128'(9));
            end
            bus.pixel_valid = 1'b0;
        end
        check_eq("ones_win_count", 128'(n_win), 128'(4));

`ifdef CONV_FRAME_SYNC_EN
        // Five pixels of a frame, then sof on the sixth restarts the raster
        n_win = 0; n_done = 0;
        for (int p = 0; p < 5; p++) step(1'b1, 200 + p, 1'b0, 1'b0, 0, p, 1'b0);
        run_frame(0, 1'b0, 1'b1);
        check_eq("sof_win_count",  128'(n_win),  128'(4));
        check_eq("sof_done_count", 128'(n_done), 128'(1));
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_conv_window_gen
`default_nettype wire
